// File: rtl/tlb_unit_pkg.sv
// Shared TLB types: entry layout, physical-translation half, INVTLB op codes and sweep states.
// Also holds the small helpers shared by the lookup and invalidation logic.
package tlb_unit_pkg;

    localparam int TLBNUM     = 16;
    localparam int TLBNUMSIZE = $clog2(TLBNUM);

    localparam logic [TLBNUMSIZE-1:0] TLB_LAST = TLBNUMSIZE'(TLBNUM - 1);

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_2M = 6'd21;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } PhytranItem;

    typedef struct packed {
        logic        e;
        logic [5:0]  ps;
        logic        g;
        logic [9:0]  asid;
        logic [18:0] vppn;
        PhytranItem  phytran0;
        PhytranItem  phytran1;
    } TlbEntry;

    typedef enum logic [4:0] {
        INV_ALL        = 5'd0,
        INV_ALL_ALT    = 5'd1,
        INV_GLOBAL     = 5'd2,
        INV_NONGLOBAL  = 5'd3,
        INV_ASID       = 5'd4,
        INV_ASID_VA    = 5'd5,
        INV_GASID_VA   = 5'd6
    } InvOp;

    typedef enum logic {
        INV_IDLE,
        INV_SWEEP
    } InvState;

    // Whether an entry is killed by an INVTLB op; unknown ops kill nothing.
    function automatic logic inv_pred(input logic [4:0] op, input logic g,
                                      input logic asid_eq, input logic va_eq);
        logic kill;
        kill = 1'b0;
        case (op)
            INV_ALL, INV_ALL_ALT: kill = 1'b1;
            INV_GLOBAL:           kill = g;
            INV_NONGLOBAL:        kill = ~g;
            INV_ASID:             kill = ~g & asid_eq;
            INV_ASID_VA:          kill = ~g & asid_eq & va_eq;
            INV_GASID_VA:         kill = (g | asid_eq) & va_eq;
            default:              kill = 1'b0;
        endcase
        return kill;
    endfunction

    // Lowest set index wins among multiple hits.
    function automatic logic [TLBNUMSIZE-1:0] first_hit(input logic [TLBNUM-1:0] hits);
        logic [TLBNUMSIZE-1:0] idx;
        idx = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (hits[i]) idx = TLBNUMSIZE'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tlb_match.sv
// Per-entry comparator: page-size aware VPPN compare, ASID equality and even/odd half select.
module tlb_match
    import tlb_unit_pkg::*;
(
    input  TlbEntry     entry,
    input  logic [18:0] vppn,
    input  logic        odd,
    input  logic [9:0]  asid,
    output logic        va_hit,
    output logic        asid_eq,
    output logic        odd_sel
);

    logic big;

    // 2MB pages ignore the low VPPN bits and use VPPN[8] to pick the half.
    assign big     = (entry.ps == PS_2M);
    assign va_hit  = big ? (entry.vppn[18:9] == vppn[18:9]) : (entry.vppn == vppn);
    assign asid_eq = (entry.asid == asid);
    assign odd_sel = big ? vppn[8] : odd;

endmodule

// File: rtl/tlb_unit.sv
// Fully associative TLB: two lookup ports, combinational read, write port and INVTLB engine.
// Define TLB_INV_ONECYCLE_EN to invalidate all entries in parallel instead of a sequenced sweep.
module tlb_unit
    import tlb_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s0_req,
    input  logic [18:0]           s0_vppn,
    input  logic                  s0_odd,
    input  logic [9:0]            s0_asid,
    output logic                  s0_valid,
    output logic                  s0_found,
    output logic [TLBNUMSIZE-1:0] s0_index,
    output logic [5:0]            s0_ps,
    output PhytranItem            s0_phy,
    input  logic                  s1_req,
    input  logic [18:0]           s1_vppn,
    input  logic                  s1_odd,
    input  logic [9:0]            s1_asid,
    output logic                  s1_valid,
    output logic                  s1_found,
    output logic [TLBNUMSIZE-1:0] s1_index,
    output logic                  s1_ne,
    input  logic [TLBNUMSIZE-1:0] r_index,
    output logic [5:0]            r_ps,
    output logic [9:0]            r_asid,
    output logic                  r_ne,
    output logic                  r_g,
    output logic [18:0]           r_vppn,
    output PhytranItem            r_phytran0,
    output PhytranItem            r_phytran1,
    input  logic                  we,
    input  logic [TLBNUMSIZE-1:0] w_index,
    input  logic [5:0]            w_ps,
    input  logic                  w_ne,
    input  logic [9:0]            w_asid,
    input  logic [18:0]           w_vppn,
    input  logic                  w_g,
    input  PhytranItem            w_phytran0,
    input  PhytranItem            w_phytran1,
    input  logic                  inv_start,
    input  logic [4:0]            inv_op,
    input  logic [9:0]            inv_asid,
    input  logic [18:0]           inv_va,
    output logic                  inv_busy,
    output logic                  inv_done
);

    TlbEntry               entries [TLBNUM];
    TlbEntry               w_entry;
    logic                  wr_en;
    logic [TLBNUM-1:0]     clr_vec;
    logic [TLBNUM-1:0]     s0_va_hit, s0_asid_eq, s0_odd_sel, s0_hit;
    logic [TLBNUM-1:0]     s1_va_hit, s1_asid_eq, s1_sel_unused, s1_hit;
    logic [TLBNUMSIZE-1:0] s0_idx, s1_idx;

    for (genvar i = 0; i < TLBNUM; i++) begin : g_lookup
        tlb_match u_s0 (
            .entry(entries[i]), .vppn(s0_vppn), .odd(s0_odd), .asid(s0_asid),
            .va_hit(s0_va_hit[i]), .asid_eq(s0_asid_eq[i]), .odd_sel(s0_odd_sel[i])
        );
        tlb_match u_s1 (
            .entry(entries[i]), .vppn(s1_vppn), .odd(s1_odd), .asid(s1_asid),
            .va_hit(s1_va_hit[i]), .asid_eq(s1_asid_eq[i]), .odd_sel(s1_sel_unused[i])
        );
        assign s0_hit[i] = entries[i].e & (entries[i].g | s0_asid_eq[i]) & s0_va_hit[i];
        assign s1_hit[i] = entries[i].e & (entries[i].g | s1_asid_eq[i]) & s1_va_hit[i];
    end

    assign s0_idx = first_hit(s0_hit);
    assign s1_idx = first_hit(s1_hit);

    // Lookup result register; outputs hold when no request is presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_valid <= 1'b0;
            s0_found <= 1'b0;
            s0_index <= '0;
            s0_ps    <= '0;
            s0_phy   <= '0;
            s1_valid <= 1'b0;
            s1_found <= 1'b0;
            s1_index <= '0;
            s1_ne    <= 1'b0;
        end else begin
            s0_valid <= s0_req;
            s1_valid <= s1_req;
            if (s0_req) begin
                s0_found <= |s0_hit;
                s0_index <= s0_idx;
                s0_ps    <= (|s0_hit) ? entries[s0_idx].ps : '0;
                s0_phy   <= !(|s0_hit)        ? '0 :
                            s0_odd_sel[s0_idx] ? entries[s0_idx].phytran1
                                               : entries[s0_idx].phytran0;
            end
            if (s1_req) begin
                s1_found <= |s1_hit;
                s1_index <= s1_idx;
                s1_ne    <= ~(|s1_hit);
            end
        end
    end

    assign r_ps       = entries[r_index].ps;
    assign r_asid     = entries[r_index].asid;
    assign r_ne       = ~entries[r_index].e;
    assign r_g        = entries[r_index].g;
    assign r_vppn     = entries[r_index].vppn;
    assign r_phytran0 = entries[r_index].phytran0;
    assign r_phytran1 = entries[r_index].phytran1;

`ifdef TLB_INV_ONECYCLE_EN
    logic [TLBNUM-1:0] inv_va_hit, inv_asid_eq, inv_sel_unused;

    for (genvar i = 0; i < TLBNUM; i++) begin : g_inv
        tlb_match u_inv (
            .entry(entries[i]), .vppn(inv_va), .odd(1'b0), .asid(inv_asid),
            .va_hit(inv_va_hit[i]), .asid_eq(inv_asid_eq[i]), .odd_sel(inv_sel_unused[i])
        );
        assign clr_vec[i] = inv_start & inv_pred(inv_op, entries[i].g, inv_asid_eq[i], inv_va_hit[i]);
    end

    assign inv_busy = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) inv_done <= 1'b0;
        else       inv_done <= inv_start;
    end
`else
    InvState               state, state_next;
    logic [TLBNUMSIZE-1:0] cnt;
    logic [4:0]            op_q;
    logic [9:0]            asid_q;
    logic [18:0]           va_q;
    logic                  sweep_clr, sweep_va_hit, sweep_asid_eq, sweep_sel_unused;

    // A single comparator walks the array, one entry per cycle.
    tlb_match u_sweep (
        .entry(entries[cnt]), .vppn(va_q), .odd(1'b0), .asid(asid_q),
        .va_hit(sweep_va_hit), .asid_eq(sweep_asid_eq), .odd_sel(sweep_sel_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INV_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            asid_q   <= '0;
            va_q     <= '0;
            inv_done <= 1'b0;
        end else begin
            state    <= state_next;
            inv_done <= (state == INV_SWEEP) && (cnt == TLB_LAST);
            if (state == INV_IDLE && inv_start) begin
                cnt    <= '0;
                op_q   <= inv_op;
                asid_q <= inv_asid;
                va_q   <= inv_va;
            end else if (state == INV_SWEEP) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        inv_busy   = 1'b0;
        sweep_clr  = 1'b0;
        case (state)
            INV_IDLE: begin
                if (inv_start) state_next = INV_SWEEP;
            end
            INV_SWEEP: begin
                inv_busy  = 1'b1;
                sweep_clr = inv_pred(op_q, entries[cnt].g, sweep_asid_eq, sweep_va_hit);
                if (cnt == TLB_LAST) state_next = INV_IDLE;
            end
            default: state_next = INV_IDLE;
        endcase
    end

    assign clr_vec = sweep_clr ? (TLBNUM'(1) << cnt) : '0;
`endif

    assign wr_en   = we & ~inv_busy;
    assign w_entry = '{e: ~w_ne, ps: w_ps, g: w_g, asid: w_asid, vppn: w_vppn,
                       phytran0: w_phytran0, phytran1: w_phytran1};

    // Invalidation clears only E; a same-edge write lands afterwards and wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) entries[i] <= '0;
        end else begin
            for (int i = 0; i < TLBNUM; i++) begin
                if (clr_vec[i]) entries[i].e <= 1'b0;
            end
            if (wr_en) entries[w_index] <= w_entry;
        end
    end

endmodule

// File: tb/tb_tlb_unit.sv
// Randomized scoreboard bench for tlb_unit against an array-based reference model.
module tb_tlb_unit;
    import tlb_unit_pkg::*;

`ifdef TLB_INV_ONECYCLE_EN
    localparam bit ONE = 1'b1;
`else
    localparam bit ONE = 1'b0;
`endif
    localparam int INV_EDGES = ONE ? 1 : TLBNUM + 1;

    logic                  clk, reset;
    logic                  s0_req, s0_odd, s1_req, s1_odd;
    logic [18:0]           s0_vppn, s1_vppn;
    logic [9:0]            s0_asid, s1_asid;
    logic                  s0_valid, s0_found, s1_valid, s1_found, s1_ne;
    logic [TLBNUMSIZE-1:0] s0_index, s1_index, r_index, w_index;
    logic [5:0]            s0_ps, r_ps, w_ps;
    PhytranItem            s0_phy, r_phytran0, r_phytran1, w_phytran0, w_phytran1;
    logic [9:0]            r_asid, w_asid, inv_asid;
    logic                  r_ne, r_g, we, w_ne, w_g;
    logic [18:0]           r_vppn, w_vppn, inv_va;
    logic                  inv_start, inv_busy, inv_done;
    logic [4:0]            inv_op;

    tlb_unit dut (
        .clk(clk), .reset(reset),
        .s0_req(s0_req), .s0_vppn(s0_vppn), .s0_odd(s0_odd), .s0_asid(s0_asid),
        .s0_valid(s0_valid), .s0_found(s0_found), .s0_index(s0_index), .s0_ps(s0_ps), .s0_phy(s0_phy),
        .s1_req(s1_req), .s1_vppn(s1_vppn), .s1_odd(s1_odd), .s1_asid(s1_asid),
        .s1_valid(s1_valid), .s1_found(s1_found), .s1_index(s1_index), .s1_ne(s1_ne),
        .r_index(r_index), .r_ps(r_ps), .r_asid(r_asid), .r_ne(r_ne), .r_g(r_g), .r_vppn(r_vppn),
        .r_phytran0(r_phytran0), .r_phytran1(r_phytran1),
        .we(we), .w_index(w_index), .w_ps(w_ps), .w_ne(w_ne), .w_asid(w_asid), .w_vppn(w_vppn),
        .w_g(w_g), .w_phytran0(w_phytran0), .w_phytran1(w_phytran1),
        .inv_start(inv_start), .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
        .inv_busy(inv_busy), .inv_done(inv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         found;
        int         idx;
        logic [5:0] ps;
        PhytranItem phy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   checks = 0;
    int   errors = 0;

    // Reference model: one plain array per field.
    bit          m_e    [TLBNUM];
    logic [5:0]  m_ps   [TLBNUM];
    bit          m_g    [TLBNUM];
    logic [9:0]  m_asid [TLBNUM];
    logic [18:0] m_vppn [TLBNUM];
    PhytranItem  m_p0   [TLBNUM];
    PhytranItem  m_p1   [TLBNUM];
    bit          m_busy;

    logic [18:0] vp_pool [4] = '{19'h12345, 19'h12355, 19'h00777, 19'h7ff00};
    PhytranItem  pa, pb;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < TLBNUM; i++) begin
            m_e[i] = 0; m_ps[i] = 0; m_g[i] = 0; m_asid[i] = 0;
            m_vppn[i] = 0; m_p0[i] = '0; m_p1[i] = '0;
        end
        m_busy = 0;
    endfunction

    function automatic bit va_match(input int i, input logic [18:0] va);
        if (m_ps[i] == 6'd21) return (m_vppn[i] >> 9) == (va >> 9);
        return m_vppn[i] == va;
    endfunction

    function automatic exp_t mlook(input logic [18:0] va, input logic odd, input logic [9:0] asid);
        exp_t r;
        bit   upper;
        r = '{found: 0, idx: 0, ps: '0, phy: '0};
        for (int i = 0; i < TLBNUM; i++) begin
            if (!r.found && m_e[i] && (m_g[i] || m_asid[i] == asid) && va_match(i, va)) begin
                r.found = 1;
                r.idx   = i;
                r.ps    = m_ps[i];
                upper   = (m_ps[i] == 6'd21) ? va[8] : odd;
                r.phy   = upper ? m_p1[i] : m_p0[i];
            end
        end
        return r;
    endfunction

    function automatic void apply_inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] va);
        bit kill, am;
        for (int i = 0; i < TLBNUM; i++) begin
            am = (m_asid[i] == asid);
            case (op)
                5'd0, 5'd1: kill = 1;
                5'd2:       kill = m_g[i];
                5'd3:       kill = !m_g[i];
                5'd4:       kill = !m_g[i] && am;
                5'd5:       kill = !m_g[i] && am && va_match(i, va);
                5'd6:       kill = (m_g[i] || am) && va_match(i, va);
                default:    kill = 0;
            endcase
            if (kill) m_e[i] = 0;
        end
    endfunction

    function automatic PhytranItem rand_phy();
        logic [31:0] rv;
        rv = $urandom();
        return rv[25:0];
    endfunction

    function automatic logic [18:0] rand_va();
        logic [18:0] v;
        v = vp_pool[$urandom_range(0, 3)];
        if ($urandom_range(0, 3) == 0) v = v ^ 19'($urandom_range(0, 511));
        return v;
    endfunction

    // Expectations are computed from pre-edge model state; the write lands after.
    task automatic tick();
        if (s0_req) q0.push_back(mlook(s0_vppn, s0_odd, s0_asid));
        if (s1_req) q1.push_back(mlook(s1_vppn, s1_odd, s1_asid));
        if (we && !m_busy) begin
            m_e[w_index] = !w_ne;      m_ps[w_index] = w_ps;     m_g[w_index] = w_g;
            m_asid[w_index] = w_asid;  m_vppn[w_index] = w_vppn;
            m_p0[w_index] = w_phytran0; m_p1[w_index] = w_phytran1;
        end
        @(posedge clk);
        #1;
        s0_req = 0; s1_req = 0; we = 0; inv_start = 0;
    endtask

    task automatic wr_entry(input int idx, input logic [5:0] ps, input logic g, input logic [9:0] asid,
                            input logic [18:0] vppn, input PhytranItem p0, input PhytranItem p1);
        we = 1; w_index = TLBNUMSIZE'(idx); w_ps = ps; w_g = g; w_asid = asid;
        w_vppn = vppn; w_ne = 0; w_phytran0 = p0; w_phytran1 = p1;
    endtask

    task automatic look0(input logic [18:0] va, input logic odd, input logic [9:0] asid);
        s0_req = 1; s0_vppn = va; s0_odd = odd; s0_asid = asid;
    endtask

    task automatic look1(input logic [18:0] va, input logic odd, input logic [9:0] asid);
        s1_req = 1; s1_vppn = va; s1_odd = odd; s1_asid = asid;
    endtask

    task automatic chk_read(input int i);
        r_index = TLBNUMSIZE'(i);
        #1;
        check($sformatf("r_ne[%0d]", i), r_ne, !m_e[i]);
        check($sformatf("r_ps[%0d]", i), r_ps, m_ps[i]);
        check($sformatf("r_g[%0d]", i), r_g, m_g[i]);
        check($sformatf("r_asid[%0d]", i), r_asid, m_asid[i]);
        check($sformatf("r_vppn[%0d]", i), r_vppn, m_vppn[i]);
        check($sformatf("r_phytran0[%0d]", i), r_phytran0, m_p0[i]);
        check($sformatf("r_phytran1[%0d]", i), r_phytran1, m_p1[i]);
    endtask

    task automatic run_inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] va, input bit disturb);
        int edges;
        inv_start = 1; inv_op = op; inv_asid = asid; inv_va = va;
        tick();
        edges = 1;
        check("busy_after_start", inv_busy, ONE ? 1'b0 : 1'b1);
        m_busy = !ONE;
        while (!inv_done && edges < 40) begin
            if (disturb && edges == 3)
                wr_entry($urandom_range(0, TLBNUM - 1), 6'd12, 0, 10'h3ff, 19'h55555, rand_phy(), rand_phy());
            if (disturb && edges == 5) begin
                inv_start = 1; inv_op = 5'd0;
            end
            tick();
            edges++;
        end
        check("inv_done_edges", edges, INV_EDGES);
        check("busy_at_done", inv_busy, 0);
        m_busy = 0;
        apply_inv(op, asid, va);
        tick();
        check("done_pulse_width", inv_done, 0);
    endtask

    // Monitor: pops one expectation for each valid result the DUT presents.
    always @(negedge clk) begin
        if (!reset && s0_valid) begin
            if (q0.size() == 0) check("s0_spurious_valid", s0_valid, 0);
            else begin
                e0 = q0.pop_front();
                check("s0_found", s0_found, e0.found);
                if (e0.found) begin
                    check("s0_index", s0_index, e0.idx);
                    check("s0_ps", s0_ps, e0.ps);
                    check("s0_phy", s0_phy, e0.phy);
                end
            end
        end
        if (!reset && s1_valid) begin
            if (q1.size() == 0) check("s1_spurious_valid", s1_valid, 0);
            else begin
                e1 = q1.pop_front();
                check("s1_found", s1_found, e1.found);
                check("s1_ne", s1_ne, !e1.found);
                if (e1.found) check("s1_index", s1_index, e1.idx);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit saw_done;
        s0_req = 0; s0_vppn = 0; s0_odd = 0; s0_asid = 0;
        s1_req = 0; s1_vppn = 0; s1_odd = 0; s1_asid = 0;
        r_index = 0; we = 0; w_index = 0; w_ps = 0; w_ne = 0; w_asid = 0; w_vppn = 0; w_g = 0;
        w_phytran0 = '0; w_phytran1 = '0; inv_start = 0; inv_op = 0; inv_asid = 0; inv_va = 0;
        pa = 26'h2aaaaaa; pb = 26'h1555555;
        model_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;

        check("rst_s0_valid", s0_valid, 0);
        check("rst_s0_found", s0_found, 0);
        check("rst_s0_index", s0_index, 0);
        check("rst_s0_ps", s0_ps, 0);
        check("rst_s0_phy", s0_phy, 0);
        check("rst_s1_valid", s1_valid, 0);
        check("rst_s1_ne", s1_ne, 0);
        check("rst_inv_busy", inv_busy, 0);
        check("rst_inv_done", inv_done, 0);
        chk_read(3);
        look1(rand_va(), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)));
        tick();

        wr_entry(5, 6'd12, 0, 10'h001, 19'h12345, pa, pb); tick();
        look0(19'h12345, 1, 10'h001); tick();
        look0(19'h12345, 1, 10'h002); tick();
        wr_entry(7, 6'd12, 0, 10'h003, 19'h00777, pa, pb); look0(19'h00777, 0, 10'h003); tick();
        look0(19'h00777, 0, 10'h003); tick();
        wr_entry(2, 6'd21, 1, 10'h155, 19'h12300, pa, pb); tick();
        look0(19'h12355, 0, 10'h3ff); look1(19'h12355, 0, 10'h3ff); tick();
        wr_entry(9, 6'd21, 1, 10'h155, 19'h12300, pb, pa); tick();
        look0(19'h12355, 1, 10'h0aa); look1(19'h12255, 0, 10'h0aa); tick();
        chk_read(5);
        chk_read(2);

        for (int i = 0; i < TLBNUM; i++) begin
            wr_entry(i, ($urandom_range(0, 1) != 0) ? 6'd21 : 6'd12, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 1) != 0) ? 10'h001 : 10'h002, rand_va(), rand_phy(), rand_phy());
            tick();
        end
        run_inv(5'd4, 10'h001, 19'h0, 1);
        for (int i = 0; i < TLBNUM; i++) chk_read(i);

`ifndef TLB_INV_ONECYCLE_EN
        inv_start = 1; inv_op = 5'd0; inv_asid = 0; inv_va = 0;
        tick();
        repeat (6) tick();
        check("busy_mid_sweep", inv_busy, 1);
        reset = 1;
        #2;
        check("busy_in_reset", inv_busy, 0);
        reset = 0;
        model_reset();
        saw_done = 0;
        repeat (20) begin
            tick();
            if (inv_done) saw_done = 1;
        end
        check("no_done_after_reset", saw_done, 0);
        chk_read(4);
`endif

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                run_inv(5'($urandom_range(0, 9)), 10'($urandom_range(0, 3)), rand_va(), 1'($urandom_range(0, 1)));
            end else begin
                if ($urandom_range(0, 2) == 0)
                    wr_entry($urandom_range(0, TLBNUM - 1), ($urandom_range(0, 1) != 0) ? 6'd21 : 6'd12,
                             1'($urandom_range(0, 1)), 10'($urandom_range(0, 3)), rand_va(), rand_phy(), rand_phy());
                if ($urandom_range(0, 1) != 0)
                    look0(rand_va(), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 3)));
                if ($urandom_range(0, 1) != 0)
                    look1(rand_va(), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 3)));
                tick();
                chk_read($urandom_range(0, TLBNUM - 1));
            end
        end

        repeat (3) tick();
        check("s0_queue_drained", q0.size(), 0);
        check("s1_queue_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
